hit_scorer: RTL
===============

HIT_SCORER -- requirements
Module: hit_scorer

Interface
REQ-001 Parameter CLK_HZ, 50000000, clock cycles per game second.
REQ-002 Parameter DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new sensor value (10 ms).
REQ-003 Parameter GAME_SECONDS, 60, round length in seconds; legal range 1..63.
REQ-004 Parameter SOUND_CYCLES, 12500000, play_sound stretch length (0.25 s).
REQ-005 Port CLOCK_50  in  1  sole clock, rising edge.
REQ-006 Port resetn  in  1  asynchronous active-low reset.
REQ-007 Port start  in  1  synchronous start request, sampled each cycle.
REQ-008 Port box_address  in  3  raw box code from read_sensor; 0 = no strike, 1..7 = box struck; asynchronous to CLOCK_50.
REQ-009 Port target_box  in  3  current target box (mif_control_signal); 0 = lobby screen.
REQ-010 Port score  out  8  packed BCD {tens, ones}.
REQ-011 Port time_left  out  6  seconds remaining, binary.
REQ-012 Port hit_pulse  out  1  one-cycle pulse on a correct strike.
REQ-013 Port miss_pulse  out  1  one-cycle pulse on a wrong strike.
REQ-014 Port play_sound  out  1  hit sound enable, stretched.
REQ-015 Port lobby_sound  out  1  high while in IDLE.
REQ-016 Port game_over  out  1  high while in OVER.

Function
REQ-017 box_address shall pass through a 2-flop synchronizer before any other use.
REQ-018 The synchronized value shall become the filtered value only after it has held unchanged for DEBOUNCE_CYCLES consecutive cycles; any change shall restart the count.
REQ-019 A strike event shall occur on the cycle the filtered value changes to a nonzero value.
REQ-020 Strike-event latency from a stable box_address change shall be 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-021 The FSM shall have three states, IDLE, PLAY and OVER, with the following transitions:
- IDLE -> PLAY on start.
- PLAY -> OVER on the second tick that takes time_left from 1 to 0.
- OVER -> PLAY on start.
- start in PLAY shall be ignored.
REQ-022 Every entry into PLAY shall load score = 8'h00 and time_left = GAME_SECONDS, and shall clear the second prescaler.
REQ-023 In PLAY, the prescaler shall count CLK_HZ cycles per tick; each tick shall decrement time_left.
REQ-024 A strike event in PLAY with value == target_box and target_box != 0 shall assert hit_pulse for one cycle and increment score in BCD (09 -> 10, 99 saturates at 99).
REQ-025 Any other strike event in PLAY shall assert miss_pulse for one cycle.
REQ-026 Strike events in IDLE or OVER shall produce no pulses and no score change.
REQ-027 A strike event coinciding with the final tick shall be scored, and the FSM shall enter OVER on the same edge.
REQ-028 hit_pulse shall load a SOUND_CYCLES down-counter; play_sound shall be high while it is nonzero. A hit during the stretch shall reload the counter.
REQ-029 score and time_left shall hold their values in OVER and IDLE; hit_pulse and miss_pulse shall never be high simultaneously.

Reset
REQ-030 While resetn = 0, the block shall asynchronously set: state = IDLE, score = 0, time_left = 0, all pulses = 0, play_sound = 0, synchronizer and filtered value = 0, all counters = 0.
REQ-031 Reset asserted mid-round shall abandon the round; after release, outputs shall be lobby_sound = 1 and game_over = 0.

Configuration
REQ-032 With MISS_PENALTY_EN defined, a wrong strike in PLAY shall decrement score in BCD (10 -> 09, 00 saturates at 00) in addition to miss_pulse; without it, score shall be unchanged on a miss.

Verification (CLK_HZ=10, DEBOUNCE_CYCLES=4, GAME_SECONDS=3, SOUND_CYCLES=5)
REQ-033 start, target_box=3, box_address 0->3 held -> hit_pulse exactly 7 cycles later, score=8'h01, play_sound high for 5 cycles.
REQ-034 box_address toggles 0/3 every 2 cycles for 20 cycles -> no strike event, score unchanged.
REQ-035 target_box=3, strike box 5 -> miss_pulse; score 8'h01 unchanged without the macro, 8'h00 with MISS_PENALTY_EN.
REQ-036 Preload 9 hits, then a 10th hit -> score=8'h10; 99 hits then one more -> score=8'h99.
REQ-037 start then idle 30 cycles -> time_left 3,2,1,0, game_over=1 at cycle 30; a strike afterwards -> no pulses.
REQ-038 resetn=0 mid-PLAY with score=8'h05 -> score=0, lobby_sound=1 immediately, no clock needed.

Source files
------------

// File: rtl/hit_scorer.sv
// hit_scorer: debounced strike scoring with a timed IDLE/PLAY/OVER round.
// Define MISS_PENALTY_EN to make a wrong strike in PLAY cost one BCD point.
module hit_scorer #(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int GAME_SECONDS    = 60,
    parameter int SOUND_CYCLES    = 12500000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] box_address,
    input  logic [2:0] target_box,
    output logic [7:0] score,
    output logic [5:0] time_left,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       play_sound,
    output logic       lobby_sound,
    output logic       game_over
);
    localparam int PW = $clog2(CLK_HZ + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(SOUND_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
    state_t state_q, state_d;

    logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [SW-1:0] snd_q, snd_d;
    logic [7:0]    score_q, score_d, score_inc;
    logic [5:0]    time_q, time_d;
    logic          hit_q, hit_d, miss_q, miss_d;
    logic          in_play, enter_play, tick, stable, accept, strike;
`ifdef MISS_PENALTY_EN
    logic [7:0]    score_dec;
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == PLAY) ? ((tick && time_q == 6'd1) ? OVER : PLAY)
                                    : (start ? PLAY : state_q);
    end

    always_comb begin
        lobby_sound = state_q == IDLE;
        game_over   = state_q == OVER;
        score       = score_q;
        time_left   = time_q;
        hit_pulse   = hit_q;
        miss_pulse  = miss_q;
        play_sound  = snd_q != '0;
    end

    always_comb begin
        in_play    = state_q == PLAY;
        enter_play = !in_play && state_d == PLAY;
        tick       = in_play && pre_q == PW'(CLK_HZ - 1);
        sync1_d    = box_address;
        sync2_d    = sync1_q;
        // sync1 == sync2 means sync2 will still hold this value after the next edge
        stable     = sync1_q == sync2_q && sync2_q != filt_q;
        accept     = stable && db_cnt_q == DW'(DEBOUNCE_CYCLES);
        db_cnt_d   = (stable && !accept) ? db_cnt_q + 1'b1 : '0;
        filt_d     = accept ? sync2_q : filt_q;
        strike     = accept && sync2_q != 3'd0;
        hit_d      = in_play && strike && sync2_q == target_box && target_box != 3'd0;
        miss_d     = in_play && strike && !hit_d;
        score_inc  = (score_q[3:0] != 4'd9) ? {score_q[7:4], score_q[3:0] + 4'd1}
                   : (score_q[7:4] != 4'd9) ? {score_q[7:4] + 4'd1, 4'd0} : score_q;
`ifdef MISS_PENALTY_EN
        score_dec  = (score_q[3:0] != 4'd0) ? {score_q[7:4], score_q[3:0] - 4'd1}
                   : (score_q[7:4] != 4'd0) ? {score_q[7:4] - 4'd1, 4'd9} : score_q;
        score_d    = enter_play ? 8'h00 : hit_d ? score_inc : miss_d ? score_dec : score_q;
`else
        score_d    = enter_play ? 8'h00 : hit_d ? score_inc : score_q;
`endif
        time_d     = enter_play ? 6'(GAME_SECONDS) : tick ? time_q - 6'd1 : time_q;
        pre_d      = (!in_play || tick) ? '0 : pre_q + 1'b1;
        snd_d      = hit_d ? SW'(SOUND_CYCLES) : (snd_q != '0) ? snd_q - 1'b1 : snd_q;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            filt_q   <= '0;
            db_cnt_q <= '0;
            pre_q    <= '0;
            snd_q    <= '0;
            score_q  <= '0;
            time_q   <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
            pre_q    <= pre_d;
            snd_q    <= snd_d;
            score_q  <= score_d;
            time_q   <= time_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end
endmodule
